// File: rtl/fft_window_mult_if.sv
// Sample stream bundle for the FFT windowing multiplier: indexed complex samples in,
// windowed complex samples out, valid-qualified with no backpressure.
interface fft_window_mult_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
);
  logic                     dv_in;
  logic [IDX_W-1:0]         index;
  logic signed [DATA_W-1:0] din_imag;
  logic signed [DATA_W-1:0] din_real;
  logic                     dv_out;
  logic signed [DATA_W-1:0] dout_imag;
  logic signed [DATA_W-1:0] dout_real;

  modport master (output dv_in, index, din_imag, din_real,
                  input  dv_out, dout_imag, dout_real);
  modport slave  (input  dv_in, index, din_imag, din_real,
                  output dv_out, dout_imag, dout_real);
endinterface

// File: rtl/fft_window_mult.sv
// Streaming complex Hann-window multiplier: 3-stage pipeline, one sample per clock,
// per-bin coefficient from an elaboration-time ROM, round-half-up and saturate.
module fft_window_lane #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               en,
  input  logic signed [DATA_W-1:0] din,
  input  logic [COEF_W-1:0]        coef,
  output logic signed [DATA_W-1:0] dout
);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [PROD_W-1:0] RND     = {{(PROD_W-1){1'b0}}, 1'b1} << (COEF_W-2);
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_W-1:0] d_q;
  logic signed [PROD_W-1:0] prod_q, prod_c, sum_c, shr_c, sat_c;
  logic signed [COEF_W:0]   coef_s;

  // Coefficient is unsigned; a zero MSB keeps 1.0 (2^(COEF_W-1)) positive in the signed multiply.
  assign coef_s = {1'b0, coef};
  assign prod_c = PROD_W'(d_q) * PROD_W'(coef_s);

  always_comb begin
    sum_c = prod_q + RND;
    shr_c = sum_c >>> (COEF_W-1);
    sat_c = shr_c;
    if (shr_c > SAT_MAX)      sat_c = SAT_MAX;
    else if (shr_c < SAT_MIN) sat_c = SAT_MIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q    <= '0;
      prod_q <= '0;
      dout   <= '0;
    end else begin
      if (en[0]) d_q    <= din;
      if (en[1]) prod_q <= prod_c;
      if (en[2]) dout   <= sat_c[DATA_W-1:0];
    end
  end
endmodule

module fft_window_mult #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5,
  parameter int COEF_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  fft_window_mult_if.slave   bus
);
  localparam int  N         = 2**IDX_W;
  localparam int  NUM_LANES = 2;
  localparam int  STAGES    = 3;
  localparam real PI        = 3.14159265358979323846;

  typedef logic [N-1:0][COEF_W-1:0] rom_t;

  // Periodic Hann; int'() of a real rounds half away from zero.
  function automatic rom_t build_rom();
    rom_t r;
    for (int n = 0; n < N; n++)
      r[n] = COEF_W'(int'((2.0**(COEF_W-1)) * (0.5 - 0.5*$cos(2.0*PI*n/N))));
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  logic [STAGES:0]                     vld_pipe;
  logic [STAGES:1]                     vld_q;
  logic [COEF_W-1:0]                   coef_q;
  logic [NUM_LANES-1:0][DATA_W-1:0]    din_l, dout_l;

  assign vld_pipe = {vld_q, bus.dv_in};
  assign din_l    = {bus.din_imag, bus.din_real};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      coef_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (bus.dv_in) coef_q <= ROM[bus.index];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fft_window_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[STAGES-1:0]),
      .din   (din_l[l]),
      .coef  (coef_q),
      .dout  (dout_l[l])
    );
  end

  assign bus.dv_out    = vld_pipe[STAGES];
  assign bus.dout_real = dout_l[0];
  assign bus.dout_imag = dout_l[1];
endmodule

// File: tb/tb_fft_window_mult.sv
// Bench for fft_window_mult: scoreboard of expected outputs tagged with their due cycle,
// a table of hand-computed vectors, a sweep, gapped random traffic and reset corners.
module tb_fft_window_mult;
  localparam int  DATA_W = 16;
  localparam int  IDX_W  = 5;
  localparam int  COEF_W = 16;
  localparam int  N      = 2**IDX_W;
  localparam real PI     = 3.14159265358979323846;

  typedef struct { int re; int im; int cyc; } exp_t;
  typedef struct { int idx; int re; int im; int ere; int eim; } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fft_window_mult_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  fft_window_mult #(.DATA_W(DATA_W), .IDX_W(IDX_W), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_pulse = 0;
  int   last_re = 0, last_im = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coef(input int n);
    return int'(32768.0 * (0.5 - 0.5*$cos(2.0*PI*n/N)));
  endfunction

  function automatic int wmul(input int x, input int w);
    longint p;
    p = (longint'(x) * w + 16384) >>> 15;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   are, aim;
    are = int'($signed(bus.dout_real));
    aim = int'($signed(bus.dout_imag));
    if (reset) begin
      checks++;
      if (bus.dv_out !== 1'b0 || are != 0 || aim != 0) begin
        errors++;
        $display("FAIL reset_state: dv_out=%b re=%0d im=%0d expected 0/0/0", bus.dv_out, are, aim);
      end
      last_re = 0; last_im = 0;
    end else if (bus.dv_out === 1'b1) begin
      n_pulse++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d re=%0d im=%0d expected no output", cyc, are, aim);
      end else begin
        e = q.pop_front();
        if (are != e.re || aim != e.im || cyc != e.cyc) begin
          errors++;
          $display("FAIL sample: got re=%0d im=%0d cyc=%0d expected re=%0d im=%0d cyc=%0d",
                   are, aim, cyc, e.re, e.im, e.cyc);
        end
      end
      last_re = are; last_im = aim;
    end else begin
      checks++;
      if (bus.dv_out !== 1'b0 || are != last_re || aim != last_im) begin
        errors++;
        $display("FAIL hold: dv_out=%b re=%0d im=%0d expected 0/%0d/%0d", bus.dv_out, are, aim, last_re, last_im);
      end
    end
  end

  task automatic send(input int idx, input int re, input int im, input int ere, input int eim);
    exp_t e;
    @(negedge clk);
    bus.dv_in    = 1'b1;
    bus.index    = idx[IDX_W-1:0];
    bus.din_real = DATA_W'(re);
    bus.din_imag = DATA_W'(im);
    e.re = ere; e.im = eim; e.cyc = cyc + 3;
    q.push_back(e);
  endtask

  task automatic send_model(input int idx, input int re, input int im);
    send(idx, re, im, wmul(re, coef(idx)), wmul(im, coef(idx)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.dv_in    = 1'b0;
      bus.index    = IDX_W'($urandom);
      bus.din_real = DATA_W'($urandom);
      bus.din_imag = DATA_W'($urandom);
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d samples outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  vec_t vecs[12];
  int   p0;

  initial begin
    vecs[0]  = '{0,      1023,      0,      0,      0};
    vecs[1]  = '{4,      1023,      0,    150,      0};
    vecs[2]  = '{8,      1023,      0,    512,      0};
    vecs[3]  = '{16,     1023,      0,   1023,      0};
    vecs[4]  = '{24,     1023,      0,    512,      0};
    vecs[5]  = '{8,     -1023,   1023,   -511,    512};
    vecs[6]  = '{16,    32767, -32768,  32767, -32768};
    vecs[7]  = '{0,     32767, -32768,      0,      0};
    vecs[8]  = '{1,     32767, -32768,    315,   -315};
    vecs[9]  = '{16,       -1,      1,     -1,      1};
    vecs[10] = '{31,     1000,  -1000,     10,    -10};
    vecs[11] = '{24,   -32768,  32767, -16384,  16384};

    bus.dv_in = 1'b0; bus.index = '0; bus.din_real = '0; bus.din_imag = '0;

    // Reset held with dv_in toggling: nothing may emerge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.dv_in = i[0]; bus.index = 5'd16; bus.din_real = 16'sd1000; bus.din_imag = -16'sd1000;
    end
    @(negedge clk);
    bus.dv_in = 1'b0;
    reset = 1'b0;
    idle(5);

    // Back-to-back sweep of all bins.
    p0 = n_pulse;
    for (int i = 0; i < N; i++) send_model(i, 1023, 0);
    drain();
    checks++;
    if (n_pulse - p0 != N) begin
      errors++;
      $display("FAIL sweep_pulses: got %0d expected %0d", n_pulse - p0, N);
    end

    // Hand-computed vectors, back to back.
    for (int i = 0; i < 12; i++) send(vecs[i].idx, vecs[i].re, vecs[i].im, vecs[i].ere, vecs[i].eim);
    drain();

    // Gapped random traffic; monitor verifies hold between pulses.
    for (int i = 0; i < 24; i++) begin
      send_model($urandom_range(N-1), int'($signed(16'($urandom))), int'($signed(16'($urandom))));
      idle(2);
    end
    drain();

    // Mid-stream reset with two samples in flight.
    send(16, 32767, -32768, 32767, -32768);
    idle(1);
    drain();
    send_model(8, 2000, -3000);
    send_model(4, -4000, 5000);
    @(negedge clk);
    bus.dv_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.dv_out !== 1'b0 || bus.dout_real !== '0 || bus.dout_imag !== '0) begin
      errors++;
      $display("FAIL async_reset: dv_out=%b re=%0d im=%0d expected 0/0/0",
               bus.dv_out, $signed(bus.dout_real), $signed(bus.dout_imag));
    end
    q.delete();
    idle(2);
    reset = 1'b0;
    idle(8);
    send_model(24, -1234, 4321);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_window_mult.md
Name: fft_window_mult

Overview:
- Streaming complex windowing multiplier that sits directly on the IFFT output stream.
- Each valid sample is scaled by a per-bin real window coefficient. The coefficient is a periodic Hann window of length 2^IDX_W, selected by the sample's bin index (the FFT tuser index field).
- The block is fully pipelined: one sample per clock, no backpressure, fixed latency.

Parameters:
- DATA_W, 16: width of the signed real and imaginary input/output samples.
- IDX_W, 5: bin index width. The window length is N = 2^IDX_W = 32.
- COEF_W, 16: unsigned coefficient width, format Q1.(COEF_W-1), so 1.0 = 2^(COEF_W-1) = 32768.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- dv_in  in  1  input sample valid.
- index  in  IDX_W  bin index of the input sample, 0..N-1.
- din_imag  in  DATA_W  signed imaginary input.
- din_real  in  DATA_W  signed real input.
- dv_out  out  1  output sample valid.
- dout_imag  out  DATA_W  signed windowed imaginary output.
- dout_real  out  DATA_W  signed windowed real output.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While reset is high, all pipeline registers, dv_out, dout_imag and dout_real are 0.
  - Deasserting reset mid-stream discards any in-flight samples. The first output after reset comes from the first dv_in accepted after deassertion.
- Coefficient ROM:
  - N entries, w[n] = round(2^(COEF_W-1) * (0.5 - 0.5*cos(2*pi*n/N))), rounding half away from zero.
  - Built at elaboration using a constant function. No runtime load port.
  - Required values for N=32: w[0]=0, w[1]=315, w[4]=4799, w[8]=16384, w[16]=32768, w[24]=16384, w[31]=315.
- Pipeline, 3 stages, fixed latency of 3 clocks from dv_in to dv_out:
  - Stage 1: register din_real, din_imag and w[index], plus a valid bit.
  - Stage 2: form two products, din x {1'b0, coef}, signed DATA_W+COEF_W+1 bits. Register them with a valid bit.
  - Stage 3: round and saturate, then register the outputs.
- Arithmetic:
  - Add 2^(COEF_W-2), then arithmetic shift right by COEF_W-1. This is round half toward +infinity.
  - Saturate to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Real and imaginary paths are independent and identical.
- Valid handling:
  - dv_out equals dv_in delayed exactly 3 clocks.
  - Back-to-back samples sustain 1 sample per clock.
  - There is no ready signal; the downstream sink must always accept.
- Output hold:
  - dout_real and dout_imag update only in cycles where stage-3 valid is 1.
  - Otherwise they hold their last value (0 after reset).
- Index handling:
  - index is sampled only when dv_in=1. It is used as-is with no wrap or check; all 2^IDX_W values are legal.
  - Gaps in dv_in and out-of-order indices are allowed; each sample uses its own index.

Test Plan:
- Reset: assert reset with dv_in toggling -> dv_out=0, dout_real=0, dout_imag=0 throughout. After release, no output until 3 clocks after the first dv_in.
- Latency and throughput: 32 consecutive samples, index 0..31, din_real=1023, din_imag=0 -> dv_out high for exactly 32 cycles, starting 3 clocks after the first dv_in. dout_real sequence includes index0=0, index4=150, index8=512, index16=1023, index24=512. dout_imag is always 0.
- Rounding sign: index=8 with din_real=-1023 and din_imag=1023 -> dout_real=-511, dout_imag=512.
- Full-scale: index=16, din_real=32767, din_imag=-32768 -> dout_real=32767, dout_imag=-32768, with no saturation artifacts. index=0 with any input -> 0/0.
- Gapped and held: dv_in pulses every 3rd cycle with random index and data -> each dv_out pulse occurs exactly 3 clocks after its dv_in and matches the reference model. Outputs hold their values between pulses.
- Mid-stream reset: assert reset while 2 samples are in flight -> neither sample emerges, and outputs return to 0 immediately (asynchronously).
